// File: rtl/cache_replace.sv
// Miss handler for the 4-way set-associative cache: picks a victim way, writes it
// back when dirty, refills the line word by word from memory and installs the new tag.
module cache_replace #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TAG_ADDR_WIDTH = 20,
   parameter int BLOCK_WIDTH    = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              rq_valid,
   input  logic [31:0]                       rq_address,
   output logic                              rq_ready,
   output logic                              rq_done,
   output logic                              sel,
   output logic [ADDR_WIDTH-1:0]             ri_readAddress,
   output logic [1:0]                        ri_readChannel,
   input  logic [31:0]                       ri_readData,
   output logic [ADDR_WIDTH-1:0]             ri_writeAddress,
   output logic [1:0]                        ri_writeChannel,
   output logic                              ri_writeEnable,
   output logic [31:0]                       ri_writeData,
   input  logic                              ri_isHaveFreeBlock,
   input  logic [1:0]                        ri_freeBlockNum,
   output logic [ADDR_WIDTH+BLOCK_WIDTH-1:0] dr_address,
   output logic [1:0]                        dr_channel,
   input  logic [31:0]                       dr_readData,
   output logic [31:0]                       dr_writeData,
   output logic                              dr_writeEnable,
   output logic [31:0]                       mem_address,
   output logic                              mem_read,
   output logic                              mem_write,
   output logic [31:0]                       mem_writeData,
   input  logic                              mem_waitRequest,
   input  logic [31:0]                       mem_readData,
   input  logic                              mem_readDataValid
);
   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_LOOKUP    = 4'd1;
   localparam logic [3:0] S_CHECK     = 4'd2;
   localparam logic [3:0] S_WB_ADDR   = 4'd3;
   localparam logic [3:0] S_WB_WRITE  = 4'd4;
   localparam logic [3:0] S_FILL      = 4'd5;
   localparam logic [3:0] S_FILL_WAIT = 4'd6;
   localparam logic [3:0] S_TAG_WR    = 4'd7;
   localparam logic [3:0] S_DONE      = 4'd8;
   localparam logic [BLOCK_WIDTH-1:0] WLAST = {BLOCK_WIDTH{1'b1}};

   logic [3:0]                state_q, state_d;
   logic [1:0]                rr_cnt_q, rr_cnt_d;
   logic [BLOCK_WIDTH-1:0]    wcnt_q, wcnt_d;
   logic [TAG_ADDR_WIDTH-1:0] tag_q, tag_d;
   logic [ADDR_WIDTH-1:0]     index_q, index_d;
   logic [BLOCK_WIDTH-1:0]    word_q, word_d;
   logic [1:0]                victim_q, victim_d;
   logic [TAG_ADDR_WIDTH-1:0] vtag_q, vtag_d;
   logic                      used_free_q, used_free_d;
   logic [31:0]               wdata_q, wdata_d;
   logic                      wb_first_q, wb_first_d;
   logic [1:0]                victim_s;
   logic                      unused_s;

   assign victim_s = ri_isHaveFreeBlock ? ri_freeBlockNum : rr_cnt_q;
   assign unused_s = ^{rq_address[1:0], ri_readData[31:TAG_ADDR_WIDTH+2], word_q};

   always_comb begin
      state_d     = state_q;
      rr_cnt_d    = rr_cnt_q;
      wcnt_d      = wcnt_q;
      tag_d       = tag_q;
      index_d     = index_q;
      word_d      = word_q;
      victim_d    = victim_q;
      vtag_d      = vtag_q;
      used_free_d = used_free_q;
      wdata_d     = wdata_q;
      wb_first_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rq_valid) begin
               tag_d   = rq_address[31:32-TAG_ADDR_WIDTH];
               index_d = rq_address[31-TAG_ADDR_WIDTH -: ADDR_WIDTH];
               word_d  = rq_address[2 +: BLOCK_WIDTH];
               wcnt_d  = {BLOCK_WIDTH{1'b0}};
               state_d = S_LOOKUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOOKUP: state_d = S_CHECK;
         S_CHECK: begin
            victim_d    = victim_s;
            vtag_d      = ri_readData[TAG_ADDR_WIDTH-1:0];
            used_free_d = ri_isHaveFreeBlock;
            if (ri_readData[TAG_ADDR_WIDTH] && ri_readData[TAG_ADDR_WIDTH+1]) begin
               state_d = S_WB_ADDR;
            end else begin
               state_d = S_FILL;
            end
         end
         S_WB_ADDR: begin
            wb_first_d = 1'b1;
            state_d    = S_WB_WRITE;
         end
         S_WB_WRITE: begin
            // The RAM word is only valid in the first cycle here; keep a copy for stalls.
            if (wb_first_q) begin
               wdata_d = dr_readData;
            end else begin
               wdata_d = wdata_q;
            end
            if (!mem_waitRequest) begin
               wcnt_d  = wcnt_q + BLOCK_WIDTH'(1);
               state_d = (wcnt_q == WLAST) ? S_FILL : S_WB_ADDR;
            end else begin
               state_d = S_WB_WRITE;
            end
         end
         S_FILL: begin
            if (!mem_waitRequest) begin
               state_d = S_FILL_WAIT;
            end else begin
               state_d = S_FILL;
            end
         end
         S_FILL_WAIT: begin
            if (mem_readDataValid) begin
               wcnt_d  = wcnt_q + BLOCK_WIDTH'(1);
               state_d = (wcnt_q == WLAST) ? S_TAG_WR : S_FILL;
            end else begin
               state_d = S_FILL_WAIT;
            end
         end
         S_TAG_WR: state_d = S_DONE;
         S_DONE: begin
            if (!used_free_q) begin
               rr_cnt_d = rr_cnt_q + 2'd1;
            end else begin
               rr_cnt_d = rr_cnt_q;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rq_ready        = 1'b0;
      rq_done         = 1'b0;
      sel             = 1'b0;
      ri_readAddress  = {ADDR_WIDTH{1'b0}};
      ri_readChannel  = 2'd0;
      ri_writeAddress = {ADDR_WIDTH{1'b0}};
      ri_writeChannel = 2'd0;
      ri_writeEnable  = 1'b0;
      ri_writeData    = 32'd0;
      dr_address      = {(ADDR_WIDTH+BLOCK_WIDTH){1'b0}};
      dr_channel      = 2'd0;
      dr_writeData    = 32'd0;
      dr_writeEnable  = 1'b0;
      mem_address     = 32'd0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_writeData   = 32'd0;
      case (state_q)
         S_IDLE:   rq_ready = 1'b1;
         S_LOOKUP: begin
            sel            = 1'b1;
            ri_readAddress = index_q;
         end
         S_CHECK: begin
            sel            = 1'b1;
            ri_readAddress = index_q;
            ri_readChannel = victim_s;
         end
         S_WB_ADDR: begin
            sel        = 1'b1;
            dr_address = {index_q, wcnt_q};
            dr_channel = victim_q;
         end
         S_WB_WRITE: begin
            sel           = 1'b1;
            mem_write     = 1'b1;
            mem_address   = {vtag_q, index_q, wcnt_q, 2'b00};
            mem_writeData = wb_first_q ? dr_readData : wdata_q;
         end
         S_FILL: begin
            sel         = 1'b1;
            mem_read    = 1'b1;
            mem_address = {tag_q, index_q, wcnt_q, 2'b00};
         end
         S_FILL_WAIT: begin
            sel            = 1'b1;
            dr_address     = {index_q, wcnt_q};
            dr_channel     = victim_q;
            dr_writeData   = mem_readData;
            dr_writeEnable = mem_readDataValid;
         end
         S_TAG_WR: begin
            sel             = 1'b1;
            ri_writeEnable  = 1'b1;
            ri_writeAddress = index_q;
            ri_writeChannel = victim_q;
            ri_writeData    = {{(32-TAG_ADDR_WIDTH-2){1'b0}}, 2'b01, tag_q};
         end
         S_DONE:  rq_done = 1'b1;
         default: rq_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_cnt_q    <= 2'd0;
         wcnt_q      <= {BLOCK_WIDTH{1'b0}};
         tag_q       <= {TAG_ADDR_WIDTH{1'b0}};
         index_q     <= {ADDR_WIDTH{1'b0}};
         word_q      <= {BLOCK_WIDTH{1'b0}};
         victim_q    <= 2'd0;
         vtag_q      <= {TAG_ADDR_WIDTH{1'b0}};
         used_free_q <= 1'b0;
         wdata_q     <= 32'd0;
         wb_first_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_cnt_q    <= rr_cnt_d;
         wcnt_q      <= wcnt_d;
         tag_q       <= tag_d;
         index_q     <= index_d;
         word_q      <= word_d;
         victim_q    <= victim_d;
         vtag_q      <= vtag_d;
         used_free_q <= used_free_d;
         wdata_q     <= wdata_d;
         wb_first_q  <= wb_first_d;
      end
   end
endmodule

// File: tb/tb_cache_replace.sv
// Directed bench for cache_replace with a small memory / data-RAM responder and
// event logs compared against hand-derived line, victim and tag expectations.
module tb_cache_replace;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        rq_valid;
   logic [31:0] rq_address;
   logic        rq_ready, rq_done, sel;
   logic [7:0]  ri_readAddress, ri_writeAddress;
   logic [1:0]  ri_readChannel, ri_writeChannel;
   logic [31:0] ri_readData, ri_writeData;
   logic        ri_writeEnable, ri_isHaveFreeBlock;
   logic [1:0]  ri_freeBlockNum;
   logic [9:0]  dr_address;
   logic [1:0]  dr_channel;
   logic [31:0] dr_readData, dr_writeData;
   logic        dr_writeEnable;
   logic [31:0] mem_address, mem_writeData, mem_readData;
   logic        mem_read, mem_write, mem_waitRequest, mem_readDataValid;

   cache_replace #(.ADDR_WIDTH(8), .TAG_ADDR_WIDTH(20), .BLOCK_WIDTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .rq_valid(rq_valid), .rq_address(rq_address),
      .rq_ready(rq_ready), .rq_done(rq_done), .sel(sel),
      .ri_readAddress(ri_readAddress), .ri_readChannel(ri_readChannel), .ri_readData(ri_readData),
      .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
      .ri_writeEnable(ri_writeEnable), .ri_writeData(ri_writeData),
      .ri_isHaveFreeBlock(ri_isHaveFreeBlock), .ri_freeBlockNum(ri_freeBlockNum),
      .dr_address(dr_address), .dr_channel(dr_channel), .dr_readData(dr_readData),
      .dr_writeData(dr_writeData), .dr_writeEnable(dr_writeEnable),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writeData(mem_writeData), .mem_waitRequest(mem_waitRequest),
      .mem_readData(mem_readData), .mem_readDataValid(mem_readDataValid));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] ram_word(input logic [1:0] ch, input logic [9:0] a);
      return 32'hD000_0000 | {20'h0_0000, ch, a};
   endfunction

   logic [31:0] rd_q[$], wr_addr_q[$], wr_data_q[$];
   logic [63:0] drw_q[$];
   int          done_cnt, tw_cnt, wr_after_rd, mem_waits;
   logic [1:0]  tw_ch;
   logic [7:0]  tw_addr;
   logic [31:0] tw_data;
   logic        prev_stall = 1'b0, rd_acc_prev = 1'b0, acc_prev = 1'b0, in_acc = 1'b0;
   logic [65:0] prev_vec;
   logic [31:0] rd_addr_prev;
   logic [9:0]  dr_addr_prev = 10'd0;
   logic [1:0]  dr_ch_prev = 2'd0;
   int          wcnt = 0;

   // Event logger: everything here is what the DUT presents to the next rising edge.
   always @(negedge clk) begin
      if (mem_read && !mem_waitRequest) rd_q.push_back(mem_address);
      if (mem_write && !mem_waitRequest) begin
         wr_addr_q.push_back(mem_address);
         wr_data_q.push_back(mem_writeData);
         if (rd_q.size() != 0) wr_after_rd++;
      end
      if (dr_writeEnable) drw_q.push_back({20'h0_0000, dr_channel, dr_address, dr_writeData});
      if (ri_writeEnable) begin
         tw_cnt++;
         tw_ch   = ri_writeChannel;
         tw_addr = ri_writeAddress;
         tw_data = ri_writeData;
      end
      if (rq_done) done_cnt++;
      if (prev_stall && (mem_read || mem_write))
         check_val("stall_hold", {mem_read, mem_write, mem_address, mem_writeData}, prev_vec);
      prev_stall   = (mem_read || mem_write) && mem_waitRequest;
      prev_vec     = {mem_read, mem_write, mem_address, mem_writeData};
      rd_acc_prev  = mem_read && !mem_waitRequest;
      acc_prev     = (mem_read || mem_write) && !mem_waitRequest;
      rd_addr_prev = mem_address;
      dr_addr_prev = dr_address;
      dr_ch_prev   = dr_channel;
   end

   // Memory and data-RAM responder, driven just after each rising edge.
   always @(posedge clk) begin
      #1;
      mem_readDataValid = rd_acc_prev;
      mem_readData      = rd_acc_prev ? mem_word(rd_addr_prev) : 32'h0;
      dr_readData       = ram_word(dr_ch_prev, dr_addr_prev);
      if (acc_prev) in_acc = 1'b0;
      if (mem_read || mem_write) begin
         if (!in_acc) begin
            in_acc = 1'b1;
            wcnt   = mem_waits;
         end else if (wcnt != 0) begin
            wcnt = wcnt - 1;
         end
         mem_waitRequest = (wcnt != 0);
      end else begin
         in_acc          = 1'b0;
         mem_waitRequest = 1'b0;
      end
   end

   task automatic clear_logs();
      rd_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); drw_q.delete();
      done_cnt = 0; tw_cnt = 0; wr_after_rd = 0;
   endtask

   task automatic run_miss(input logic [31:0] addr, input logic free, input logic [1:0] fnum,
                           input logic [31:0] tagword, input int waits, input logic pulse,
                           output int lat);
      int n;
      clear_logs();
      ri_readData = tagword; ri_isHaveFreeBlock = free; ri_freeBlockNum = fnum; mem_waits = waits;
      @(negedge clk); #1;
      check_val("rq_ready_idle", rq_ready, 1);
      rq_valid = 1'b1; rq_address = addr;
      @(negedge clk); #1;
      rq_valid = 1'b0;
      n = 1;
      while (!rq_done && n < 400) begin
         if (pulse && n == 8) begin
            rq_valid = 1'b1; rq_address = 32'hFFFF_FFF0;
         end else begin
            rq_valid = 1'b0;
         end
         @(negedge clk); #1;
         n++;
      end
      rq_valid = 1'b0;
      check_val("done_seen", rq_done, 1);
      lat = n;
      repeat (20) @(negedge clk);
      #1;
   endtask

   task automatic verify(input logic [19:0] tag, input logic [7:0] idx, input logic [1:0] victim,
                         input logic dirty, input logic [19:0] vtag);
      logic [1:0]  w;
      logic [31:0] a;
      check_val("read_count", rd_q.size(), 4);
      check_val("dr_write_count", drw_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         w = 2'(i);
         a = {tag, idx, w, 2'b00};
         if (i < rd_q.size()) check_val("read_addr", rd_q[i], a);
         if (i < drw_q.size()) check_val("dr_write", drw_q[i], {20'h0_0000, victim, idx, w, mem_word(a)});
      end
      if (dirty) begin
         check_val("wb_count", wr_addr_q.size(), 4);
         check_val("wb_before_fill", wr_after_rd, 0);
         for (int i = 0; i < 4; i++) begin
            w = 2'(i);
            if (i < wr_addr_q.size()) begin
               check_val("wb_addr", wr_addr_q[i], {vtag, idx, w, 2'b00});
               check_val("wb_data", wr_data_q[i], ram_word(victim, {idx, w}));
            end
         end
      end else begin
         check_val("no_wb", wr_addr_q.size(), 0);
      end
      check_val("tag_wr_count", tw_cnt, 1);
      check_val("tag_wr_way", tw_ch, victim);
      check_val("tag_wr_set", tw_addr, idx);
      check_val("tag_wr_data", tw_data, {10'h000, 2'b01, tag});
      check_val("done_count", done_cnt, 1);
      check_val("rq_ready_after", rq_ready, 1);
   endtask

   function automatic logic outs_or();
      return |{rq_done, sel, ri_readAddress, ri_readChannel, ri_writeAddress, ri_writeChannel,
               ri_writeEnable, ri_writeData, dr_address, dr_channel, dr_writeData, dr_writeEnable,
               mem_address, mem_read, mem_write, mem_writeData};
   endfunction

   initial begin
      int lat;
      logic [31:0] a;
      logic [1:0]  v;
      rst_n = 1'b0; rq_valid = 1'b0; rq_address = 32'h0;
      ri_readData = 32'h0; ri_isHaveFreeBlock = 1'b0; ri_freeBlockNum = 2'd0;
      dr_readData = 32'h0; mem_waitRequest = 1'b0; mem_readData = 32'h0; mem_readDataValid = 1'b0;
      mem_waits = 0;
      repeat (3) @(negedge clk);
      #1;
      check_val("reset_ready", rq_ready, 1);
      check_val("reset_outs_zero", outs_or(), 0);
      rst_n = 1'b1;

      // Free way 2: refill only, 12-cycle latency, round-robin untouched.
      run_miss(32'h0000_1230, 1'b1, 2'd2, 32'h0, 0, 1'b0, lat);
      check_val("latency", lat, 12);
      verify(20'h00001, 8'h23, 2'd2, 1'b0, 20'h0);

      // Full set, clean victim: round-robin 0 -> 1.
      run_miss(32'h0004_5670, 1'b0, 2'd0, 32'h0010_0055, 0, 1'b0, lat);
      verify(20'h00045, 8'h67, 2'd0, 1'b0, 20'h0);

      // Full set, dirty victim at round-robin 1; requested word 3 still refills from word 0.
      run_miss(32'h0007_89AC, 1'b0, 2'd0, 32'h0030_00AB, 0, 1'b0, lat);
      verify(20'h00078, 8'h9A, 2'd1, 1'b1, 20'h000AB);

      // Three wait states on every access plus a stray request mid-refill.
      run_miss(32'hABCD_E124, 1'b0, 2'd0, 32'h0030_0F0F, 3, 1'b1, lat);
      verify(20'hABCDE, 8'h12, 2'd2, 1'b1, 20'h00F0F);

      // Reset while waiting for refill data.
      clear_logs();
      ri_readData = 32'h0; ri_isHaveFreeBlock = 1'b1; ri_freeBlockNum = 2'd1; mem_waits = 0;
      @(negedge clk); #1;
      rq_valid = 1'b1; rq_address = 32'h0000_2340;
      @(negedge clk); #1;
      rq_valid = 1'b0;
      for (int i = 0; i < 100 && rd_q.size() < 2; i++) begin
         @(negedge clk); #1;
      end
      @(negedge clk); #1;
      check_val("pre_reset_dr_we", dr_writeEnable, 1);
      rst_n = 1'b0;
      #1;
      check_val("abort_outs_zero", outs_or(), 0);
      check_val("abort_ready", rq_ready, 1);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check_val("abort_no_tag_wr", tw_cnt, 0);
      check_val("abort_no_done", done_cnt, 0);
      check_val("abort_idle_ready", rq_ready, 1);

      // Five full-set misses after reset: victims 0,1,2,3,0.
      for (int i = 0; i < 5; i++) begin
         a = 32'h0010_0000 + 32'(i) * 32'h0000_1010;
         v = 2'(i);
         run_miss(a, 1'b0, 2'd3, 32'h0010_0123, 0, 1'b0, lat);
         verify(a[31:12], a[11:4], v, 1'b0, 20'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
